// File: rtl/paddle_ctrl.sv
// Paddle controller: joystick or ball-tracking movement with acceleration,
// wall clamping, pause, and a registered pixel-colour output for the renderer.
module paddle_ctrl #(
  parameter int unsigned SCREEN_Y    = 480,
  parameter int unsigned PADDLE_W    = 10,
  parameter int unsigned PADDLE_H    = 70,
  parameter int unsigned X_POS       = 5,
  parameter int unsigned TICK_DIV    = 10,
  parameter int unsigned STEP_MIN    = 1,
  parameter int unsigned STEP_MAX    = 4,
  parameter int unsigned ACCEL_TICKS = 8,
  parameter int unsigned DEADBAND    = 4,
  parameter logic [2:0]  COLOR       = 3'b111
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic [9:0] i_row,
  input  logic [9:0] i_col,
  input  logic       i_control_up,
  input  logic       i_control_down,
  input  logic       i_ai_mode,
  input  logic [9:0] i_ball_y,
  input  logic       i_pause,
  output logic [2:0] o_rgb,
  output logic [9:0] o_pos_x,
  output logic [9:0] o_pos_y,
  output logic [7:0] o_size_x,
  output logic [7:0] o_size_y,
  output logic       o_at_top,
  output logic       o_at_bottom
);

  localparam int unsigned POS_W   = 10;
  localparam int unsigned CALC_W  = 12;
  localparam int unsigned CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned ACC_W   = (ACCEL_TICKS > 0) ? $clog2(ACCEL_TICKS + 1) : 1;
  localparam int unsigned Y_MAX   = SCREEN_Y - PADDLE_H;
  localparam int unsigned Y_RESET = Y_MAX / 2;

  typedef enum logic [1:0] {ST_HOLD, ST_MOVE_SLOW, ST_MOVE_FAST} state_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DOWN} dir_t;

  logic [CNT_W-1:0] r_tick_cnt;
  state_t           r_state;
  dir_t             r_dir;
  logic             r_mode;
  logic [ACC_W-1:0] r_accel;
  logic [POS_W-1:0] r_pos_y;
  logic [2:0]       r_rgb;
  logic             r_at_top;
  logic             r_at_bottom;

  logic                     w_tick;
  dir_t                     w_dir;
  logic                     w_continue;
  logic [CALC_W-1:0]        w_centre;
  logic [CALC_W-1:0]        w_ball;
  logic [CALC_W-1:0]        w_step;
  logic signed [CALC_W-1:0] w_pos_raw;
  logic [POS_W-1:0]         w_pos_next;
  logic [ACC_W-1:0]         w_accel_next;
  state_t                   w_state_next;
  logic                     w_in_x;
  logic                     w_in_y;

  assign w_tick   = (r_tick_cnt == CNT_W'(TICK_DIV - 1));
  assign w_centre = CALC_W'(r_pos_y) + CALC_W'(PADDLE_H / 2);
  assign w_ball   = CALC_W'(i_ball_y);

  // Requested direction from the joystick or from ball tracking
  always_comb begin
    w_dir = DIR_NONE;
    if (i_ai_mode) begin
      if (w_ball > w_centre + CALC_W'(DEADBAND))
        w_dir = DIR_DOWN;
      else if (w_ball + CALC_W'(DEADBAND) < w_centre)
        w_dir = DIR_UP;
    end else begin
      if (i_control_up && !i_control_down)
        w_dir = DIR_UP;
      else if (i_control_down && !i_control_up)
        w_dir = DIR_DOWN;
    end
  end

  // Step size, acceleration bookkeeping and clamped next position
  always_comb begin
    w_continue   = (r_state != ST_HOLD) && (w_dir == r_dir) && (i_ai_mode == r_mode);
    w_step       = (w_continue && (r_state == ST_MOVE_FAST) && !i_ai_mode)
                   ? CALC_W'(STEP_MAX) : CALC_W'(STEP_MIN);
    w_accel_next = ACC_W'(1);
    if (w_continue)
      w_accel_next = (r_accel >= ACC_W'(ACCEL_TICKS)) ? r_accel : r_accel + ACC_W'(1);
    w_state_next = (w_accel_next >= ACC_W'(ACCEL_TICKS)) ? ST_MOVE_FAST : ST_MOVE_SLOW;
    w_pos_raw    = $signed(CALC_W'(r_pos_y));
    if (w_dir == DIR_UP)
      w_pos_raw = $signed(CALC_W'(r_pos_y)) - $signed(w_step);
    else if (w_dir == DIR_DOWN)
      w_pos_raw = $signed(CALC_W'(r_pos_y)) + $signed(w_step);
    if (w_pos_raw < $signed(CALC_W'(0)))
      w_pos_next = POS_W'(0);
    else if (w_pos_raw > $signed(CALC_W'(Y_MAX)))
      w_pos_next = POS_W'(Y_MAX);
    else
      w_pos_next = POS_W'(w_pos_raw);
  end

  // Pixel hit test against the current paddle rectangle
  always_comb begin
    w_in_x = (CALC_W'(i_col) >= CALC_W'(X_POS)) &&
             (CALC_W'(i_col) <  CALC_W'(X_POS + PADDLE_W));
    w_in_y = (CALC_W'(i_row) >= CALC_W'(r_pos_y)) &&
             (CALC_W'(i_row) <  CALC_W'(r_pos_y) + CALC_W'(PADDLE_H));
  end

  // Tick divider, movement FSM, position, flags and pixel colour
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_tick_cnt  <= '0;
      r_state     <= ST_HOLD;
      r_dir       <= DIR_NONE;
      r_mode      <= 1'b0;
      r_accel     <= '0;
      r_pos_y     <= POS_W'(Y_RESET);
      r_rgb       <= 3'b000;
      r_at_top    <= 1'b0;
      r_at_bottom <= 1'b0;
    end else begin
      r_tick_cnt  <= w_tick ? '0 : r_tick_cnt + CNT_W'(1);
      r_rgb       <= (w_in_x && w_in_y) ? COLOR : 3'b000;
      r_at_top    <= (r_pos_y == POS_W'(0));
      r_at_bottom <= (r_pos_y == POS_W'(Y_MAX));
      if (w_tick) begin
        r_mode <= i_ai_mode;
        if (i_pause || (w_dir == DIR_NONE)) begin
          r_state <= ST_HOLD;
          r_dir   <= DIR_NONE;
          r_accel <= '0;
        end else begin
          r_state <= w_state_next;
          r_dir   <= w_dir;
          r_accel <= w_accel_next;
          r_pos_y <= w_pos_next;
        end
      end
    end
  end

  assign o_rgb       = r_rgb;
  assign o_pos_y     = r_pos_y;
  assign o_at_top    = r_at_top;
  assign o_at_bottom = r_at_bottom;
  assign o_pos_x     = POS_W'(X_POS);
  assign o_size_x    = 8'(PADDLE_W);
  assign o_size_y    = 8'(PADDLE_H);

endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed bench for paddle_ctrl with default parameters.
module tb_paddle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] row = '0;
  logic [9:0] col = '0;
  logic       up = 1'b0;
  logic       down = 1'b0;
  logic       ai = 1'b0;
  logic [9:0] ball = '0;
  logic       pause = 1'b0;
  logic [2:0] rgb;
  logic [9:0] pos_x;
  logic [9:0] pos_y;
  logic [7:0] size_x;
  logic [7:0] size_y;
  logic       at_top;
  logic       at_bottom;

  int n_tests = 0;
  int n_fail  = 0;

  paddle_ctrl dut (
    .i_clock(clk), .i_reset(reset), .i_row(row), .i_col(col),
    .i_control_up(up), .i_control_down(down), .i_ai_mode(ai),
    .i_ball_y(ball), .i_pause(pause), .o_rgb(rgb), .o_pos_x(pos_x),
    .o_pos_y(pos_y), .o_size_x(size_x), .o_size_y(size_y),
    .o_at_top(at_top), .o_at_bottom(at_bottom)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reset for two edges; release 1 time unit after the last one
  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Advance exactly one movement tick (10 edges) and sample after it
  task automatic tick();
    repeat (10) @(posedge clk);
    #1;
  endtask

  initial begin
    int exp;
    int prev;
    bit reached;

    // Reset values
    do_reset();
    chk("rst_pos_y", pos_y, 205);
    chk("rst_pos_x", pos_x, 5);
    chk("rst_size_x", size_x, 10);
    chk("rst_size_y", size_y, 70);
    chk("rst_rgb", rgb, 0);
    chk("rst_top", at_top, 0);
    chk("rst_bottom", at_bottom, 0);

    // Drawing at pos_y=205, one-cycle latency
    row = 10'd205; col = 10'd5;  @(posedge clk); #1 chk("draw_corner", rgb, 7);
    col = 10'd15;                @(posedge clk); #1 chk("draw_col15", rgb, 0);
    row = 10'd274; col = 10'd14; @(posedge clk); #1 chk("draw_far_corner", rgb, 7);
    row = 10'd275; col = 10'd5;  @(posedge clk); #1 chk("draw_row275", rgb, 0);
    row = 10'd204;               @(posedge clk); #1 chk("draw_row204", rgb, 0);

    // Manual up with acceleration, first tick 10 cycles after release
    do_reset();
    up = 1'b1;
    repeat (9) @(posedge clk);
    #1 chk("first_tick_early", pos_y, 205);
    @(posedge clk);
    #1 chk("first_tick", pos_y, 204);
    for (int k = 2; k <= 8; k++) begin
      tick();
      chk("up_slow", pos_y, 205 - k);
    end
    tick(); chk("up_fast9", pos_y, 193);
    tick(); chk("up_fast10", pos_y, 189);
    up = 1'b0;
    tick(); chk("release_hold", pos_y, 189);
    up = 1'b1;
    tick(); chk("step_back_1", pos_y, 188);
    down = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("both_hold", pos_y, 188);
    end
    down = 1'b0;
    tick(); chk("after_both_slow", pos_y, 187);
    for (int k = 2; k <= 8; k++) begin
      tick();
      chk("up_slow2", pos_y, 188 - k);
    end
    tick(); chk("up_fast_again", pos_y, 176);

    // Reset while in fast movement, up still held
    do_reset();
    chk("rst_mid_pos", pos_y, 205);
    repeat (10) @(posedge clk);
    #1 chk("rst_mid_tick1", pos_y, 204);
    tick(); chk("rst_mid_tick2", pos_y, 203);
    up = 1'b0;

    // Down until clamped at 410
    do_reset();
    down = 1'b1;
    exp = 205; reached = 1'b0;
    for (int n = 1; n <= 80 && !reached; n++) begin
      tick();
      exp = exp + ((n <= 8) ? 1 : 4);
      if (exp > 410) exp = 410;
      chk("down_pos", pos_y, exp);
      if (exp == 410) reached = 1'b1;
    end
    chk("bottom_reached", int'(reached), 1);
    chk("bottom_flag_lag", at_bottom, 0);
    @(posedge clk); #1 chk("bottom_flag", at_bottom, 1);
    repeat (9) @(posedge clk); #1;
    tick(); chk("wall_push", pos_y, 410);
    down = 1'b0; up = 1'b1;
    tick(); chk("leave_bottom", pos_y, 409);
    chk("bottom_flag_still", at_bottom, 1);
    @(posedge clk); #1 chk("bottom_flag_clear", at_bottom, 0);
    up = 1'b0;

    // AI tracking ball_y=300 with a pause during travel
    do_reset();
    ai = 1'b1; ball = 10'd300;
    exp = 205;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (exp < 261) exp++;
      chk("ai_down", pos_y, exp);
    end
    pause = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("ai_pause", pos_y, 225);
    end
    pause = 1'b0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (exp < 261) exp++;
      chk("ai_resume", pos_y, exp);
    end
    chk("ai_stop", pos_y, 261);

    // AI tracking to the top wall
    ball = 10'd0;
    for (int n = 0; n < 265; n++) begin
      prev = exp;
      tick();
      if (exp > 0) exp--;
      chk("ai_up", pos_y, exp);
      chk("ai_top_flag", at_top, (prev == 0) ? 1 : 0);
    end
    chk("ai_at_top", at_top, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/paddle_ctrl.md
PADDLE_CTRL -- requirements
Module: paddle_ctrl

Interface
REQ-001 Parameter SCREEN_Y, 480: visible rows; paddle travel limit.
REQ-002 Parameter PADDLE_W, 10: paddle width in pixels (<=255).
REQ-003 Parameter PADDLE_H, 70: paddle height in pixels (<=255, <SCREEN_Y).
REQ-004 Parameter X_POS, 5: fixed left column of paddle.
REQ-005 Parameter TICK_DIV, 10: clock cycles per movement tick (>=1, any width; counter sized by $clog2).
REQ-006 Parameter STEP_MIN, 1 / STEP_MAX, 4: pixels per tick before/after acceleration.
REQ-007 Parameter ACCEL_TICKS, 8: consecutive same-direction move ticks before switching to STEP_MAX.
REQ-008 Parameter DEADBAND, 4: AI-mode tolerance in pixels; COLOR, 3'b111: draw colour.
REQ-009 clock  in  1  single clock; all state updates on its rising edge.
REQ-010 reset  in  1  synchronous, active-high reset.
REQ-011 row, col  in  10 each  pixel currently being scanned.
REQ-012 control_up, control_down  in  1 each  joystick direction requests (manual mode).
REQ-013 ai_mode  in  1  0 = joystick control, 1 = track ball_y.
REQ-014 ball_y  in  10  ball centre row used in AI mode.
REQ-015 pause  in  1  1 freezes paddle position.
REQ-016 rgb  out  3  registered pixel colour; pos_x, pos_y  out  10 each  paddle top-left; size_x, size_y  out  8 each  PADDLE_W, PADDLE_H.
REQ-017 at_top, at_bottom  out  1 each  registered flags: pos_y==0 / pos_y==SCREEN_Y-PADDLE_H.

Function
REQ-018 Tick counter counts 0..TICK_DIV-1 and wraps; tick is asserted in the cycle the counter equals TICK_DIV-1; counter runs regardless of pause.
REQ-019 Position changes only on tick cycles; row 0 is top, "up" decreases pos_y.
REQ-020 Manual mode direction: up only -> UP; down only -> DOWN; both or neither -> HOLD (no move, acceleration cleared).
REQ-021 AI mode: centre = pos_y + PADDLE_H/2; DOWN if ball_y > centre+DEADBAND; UP if ball_y+DEADBAND < centre; else HOLD; control_up/down ignored; step fixed at STEP_MIN.
REQ-022 Movement FSM states HOLD, MOVE_SLOW, MOVE_FAST: HOLD->MOVE_SLOW on first move tick; MOVE_SLOW->MOVE_FAST after ACCEL_TICKS consecutive same-direction move ticks; any HOLD tick, direction reversal, mode change or pause -> HOLD/MOVE_SLOW with accel count cleared (reversal re-enters MOVE_SLOW in new direction).
REQ-023 Step is STEP_MIN in MOVE_SLOW, STEP_MAX in MOVE_FAST; ACCEL_TICKS ticks at STEP_MIN are applied before first STEP_MAX tick.
REQ-024 Next position computed at 11+ bits signed; result clamped to [0, SCREEN_Y-PADDLE_H]; no wrap-around ever.
REQ-025 Move into a wall while already at that limit: position unchanged, state still advances (accel count keeps counting).
REQ-026 pause=1: pos_y held, FSM forced to HOLD on each tick; release resumes from HOLD.
REQ-027 rgb registered, 1-cycle latency: COLOR when X_POS<=col<X_POS+PADDLE_W and pos_y<=row<pos_y+PADDLE_H (pos_y value at sampling cycle), else 3'b000.
REQ-028 pos_x, size_x, size_y constant X_POS, PADDLE_W, PADDLE_H at all times after reset.
REQ-029 at_top/at_bottom updated the cycle after pos_y changes.

Reset
REQ-030 reset=1 at a rising edge sets: pos_y=(SCREEN_Y-PADDLE_H)/2 (205 default), pos_x=X_POS, size_x=PADDLE_W, size_y=PADDLE_H, rgb=0, at_top=0, at_bottom=0, tick counter=0, FSM=HOLD, accel count=0.
REQ-031 Reset mid-movement or mid-acceleration overrides all other inputs that cycle; first tick after release occurs TICK_DIV cycles later.

Verification
REQ-032 Reset, defaults -> pos_y=205, pos_x=5, size 10/70, rgb=0, flags 0; first tick 10 cycles after release.
REQ-033 Manual up held 9 ticks -> pos_y 204,203,...,197 over first 8 ticks, then 193 on 9th; release one tick then up -> step back to 1.
REQ-034 Down held from 205 until clamp -> pos_y never exceeds 410, at_bottom=1 one cycle after reaching 410; up then clears it.
REQ-035 up=down=1 for 5 ticks -> pos_y unchanged, FSM HOLD; reset asserted while in MOVE_FAST -> pos_y=205, step=1 afterwards.
REQ-036 AI mode, ball_y=300, pos_y=205 -> moves down 1/tick, stops at pos_y=261 (centre 296); pause=1 during travel -> pos_y frozen.
REQ-037 Draw at pos_y=205: row=205,col=5 -> rgb=7 next cycle; col=15 or row=275 -> rgb=0.
